// File: rtl/aes_pkg.sv
// Shared constants for the AES round sequencer: block width, round counts, FSM encoding.
// No logic; imported by the sequencer, its FSM and its interface.
// No flow control of its own.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KEY0 = 2'd1,
        S_RND  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Plaintext, subkey, round-function and ciphertext buses of the AES round sequencer.
// master = sequencer side, slave = surrounding source/key-schedule/round-function/sink.
// valid/ready on the block paths, req/valid on the subkey path.
interface aes_round_sequencer_if #(
    parameter int KW = 4
) ();

    logic                           in_valid;
    logic                           in_ready;
    logic [aes_pkg::AES_BLK_W-1:0]  in_block;

    logic                           key_req;
    logic [KW-1:0]                  key_idx;
    logic                           key_valid;
    logic [aes_pkg::AES_BLK_W-1:0]  key_word;

    logic [aes_pkg::AES_BLK_W-1:0]  rf_state;
    logic                           rf_final;
    logic [aes_pkg::AES_BLK_W-1:0]  rf_result;

    logic                           out_valid;
    logic                           out_ready;
    logic [aes_pkg::AES_BLK_W-1:0]  out_block;

    modport master (
        input  in_valid, in_block, key_valid, key_word, rf_result, out_ready,
        output in_ready, key_req, key_idx, rf_state, rf_final, out_valid, out_block
    );

    modport slave (
        output in_valid, in_block, key_valid, key_word, rf_result, out_ready,
        input  in_ready, key_req, key_idx, rf_state, rf_final, out_valid, out_block
    );

endinterface

// File: rtl/aes_round_fsm.sv
// Control for the AES round sequencer: state register, round counter, handshake decode.
// Registered state; every output is decoded combinationally from state, rnd and inputs.
// Holds in KEY0/RND while key_valid is low and in DONE while out_ready is low.
module aes_round_fsm
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          abort,
    input  logic          in_valid,
    input  logic          key_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          key_req,
    output logic [KW-1:0] key_idx,
    output logic          rf_final,
    output logic          out_valid,
    output logic          busy,
    output logic          ld_in,
    output logic          ld_key0,
    output logic          ld_rnd,
    output logic          clr
);

    localparam logic [KW-1:0] RND_LAST = KW'(NR);

    state_t        state, state_nxt;
    logic [KW-1:0] rnd, rnd_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rnd   <= '0;
        end else begin
            state <= state_nxt;
            rnd   <= rnd_nxt;
        end
    end

    // abort outranks key_valid/out_ready in every busy state
    always_comb begin
        state_nxt = state;
        rnd_nxt   = rnd;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt = S_KEY0;
                    rnd_nxt   = '0;
                end
            end
            S_KEY0: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    rnd_nxt   = '0;
                end else if (key_valid) begin
                    state_nxt = S_RND;
                    rnd_nxt   = KW'(1);
                end
            end
            S_RND: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    rnd_nxt   = '0;
                end else if (key_valid) begin
                    if (rnd == RND_LAST) state_nxt = S_DONE;
                    else                 rnd_nxt   = rnd + KW'(1);
                end
            end
            S_DONE: begin
                if (abort || out_ready) begin
                    state_nxt = S_IDLE;
                    rnd_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                rnd_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        key_req   = (state == S_KEY0) || (state == S_RND);
        key_idx   = (state == S_RND) ? rnd : '0;
        rf_final  = (state == S_RND) && (rnd == RND_LAST);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        ld_in     = (state == S_IDLE) && in_valid;
        ld_key0   = (state == S_KEY0) && key_valid && !abort;
        ld_rnd    = (state == S_RND)  && key_valid && !abort;
        clr       = abort && (state != S_IDLE);
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Sequences one AES encryption over an external combinational round function; AES_ABORT_EN adds an abort port.
// Latency NR+2 cycles from accept to out_valid with subkeys always valid, +1 per key_valid-low cycle.
// in_ready only in IDLE; DONE holds out_valid/out_block until out_ready.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int KW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef AES_ABORT_EN
    input  logic                 abort,
`endif
    aes_round_sequencer_if.master bus,
    output logic                 busy
);

    logic                 abort_i;
    logic                 ld_in, ld_key0, ld_rnd, clr;
    logic [AES_BLK_W-1:0] st;

`ifdef AES_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    aes_round_fsm #(
        .NR (NR),
        .KW (KW)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort_i),
        .in_valid  (bus.in_valid),
        .key_valid (bus.key_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .key_req   (bus.key_req),
        .key_idx   (bus.key_idx),
        .rf_final  (bus.rf_final),
        .out_valid (bus.out_valid),
        .busy      (busy),
        .ld_in     (ld_in),
        .ld_key0   (ld_key0),
        .ld_rnd    (ld_rnd),
        .clr       (clr)
    );

    // st doubles as the round-function input and the ciphertext holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       st <= '0;
        else if (clr)     st <= '0;
        else if (ld_in)   st <= bus.in_block;
        else if (ld_key0) st <= st ^ bus.key_word;
        else if (ld_rnd)  st <= bus.rf_result ^ bus.key_word;
    end

    assign bus.rf_state  = st;
    assign bus.out_block = st;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: AES-128 reference, key stalls, sink backpressure, reset and abort.
module tb_aes_round_sequencer;
    import aes_pkg::*;

    localparam int NR = NR_AES128;
    localparam int KW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
`ifdef AES_ABORT_EN
    logic abort;
`endif

    always #5 clk = ~clk;

    aes_round_sequencer_if #(.KW(KW)) bus ();

    aes_round_sequencer #(.NR(NR), .KW(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef AES_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus),
        .busy  (busy)
    );

    int total = 0;
    int bad   = 0;
    logic [127:0] rk    [0:NR];
    logic [127:0] stage [0:NR];
    logic [127:0] last_out;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, base;
        int e;
        inv = 8'h01; base = x; e = 254;
        while (e != 0) begin
            if ((e & 1) != 0) inv = gmul(inv, base);
            base = gmul(base, base);
            e = e >> 1;
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] x0, x1, x2, x3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[rr+4*c] = a[rr+4*((c+rr)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
                b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
                b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
                b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
                b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r;
    endfunction

    // the round function the sequencer drives
    assign bus.rf_result = aes_round(bus.rf_state, bus.rf_final);

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic build_model(input logic [127:0] pt);
        stage[0] = pt ^ rk[0];
        for (int r = 1; r <= NR; r++) stage[r] = aes_round(stage[r-1], r == NR) ^ rk[r];
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  128'(bus.in_ready),  128'd1);
        chk({tag, "_key_req"},   128'(bus.key_req),   128'd0);
        chk({tag, "_key_idx"},   128'(bus.key_idx),   128'd0);
        chk({tag, "_rf_final"},  128'(bus.rf_final),  128'd0);
        chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
        chk({tag, "_busy"},      128'(busy),          128'd0);
        chk({tag, "_rf_state"},  bus.rf_state,        128'd0);
        chk({tag, "_out_block"}, bus.out_block,       128'd0);
    endtask

    // One block end to end. pct: % chance a subkey is withheld per cycle; stall_at/stall_n: forced
    // stall cycles at one index; hold: out_ready-low cycles in DONE; b2b: keep in_valid up with next_pt;
    // rst_at/abort_at: key index at which to reset/abort (-1 none, abort_at 99 = abort in the accept cycle).
    task automatic run_block(input logic [127:0] pt, input int pct, input int stall_at, input int stall_n,
                             input int hold, input bit b2b, input logic [127:0] next_pt,
                             input int rst_at, input int abort_at);
        int k, stalled;
        bit kv;
        build_model(pt);
        chk("accept_in_ready", 128'(bus.in_ready), 128'd1);
        bus.in_valid  = 1'b1;
        bus.in_block  = pt;
        bus.key_valid = 1'($urandom_range(0, 1));
        bus.key_word  = rand128();
`ifdef AES_ABORT_EN
        abort = (abort_at == 99);
`endif
        tick();
`ifdef AES_ABORT_EN
        abort = 1'b0;
`endif
        bus.in_valid = 1'b0;
        bus.in_block = rand128();
        k = 0; stalled = 0;
        while (k <= NR) begin
            chk($sformatf("key_req_%0d", k),   128'(bus.key_req),   128'd1);
            chk($sformatf("key_idx_%0d", k),   128'(bus.key_idx),   128'(k));
            chk($sformatf("in_ready_%0d", k),  128'(bus.in_ready),  128'd0);
            chk($sformatf("busy_%0d", k),      128'(busy),          128'd1);
            chk($sformatf("out_valid_%0d", k), 128'(bus.out_valid), 128'd0);
            if (k > 0) begin
                chk($sformatf("rf_final_%0d", k), 128'(bus.rf_final), 128'(k == NR));
                chk($sformatf("rf_state_%0d", k), bus.rf_state, stage[k-1]);
            end
            if (k == rst_at) begin
                bus.key_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
                tick();
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
`ifdef AES_ABORT_EN
            if (k == abort_at) begin
                abort = 1'b1;
                bus.key_valid = 1'b1;
                bus.key_word  = rk[k];
                tick();
                abort = 1'b0;
                bus.key_valid = 1'b0;
                chk("abort_in_ready",  128'(bus.in_ready),  128'd1);
                chk("abort_busy",      128'(busy),          128'd0);
                chk("abort_out_valid", 128'(bus.out_valid), 128'd0);
                chk("abort_key_req",   128'(bus.key_req),   128'd0);
                chk("abort_st",        bus.out_block,       128'd0);
                return;
            end
`endif
            if (k == stall_at && stalled < stall_n) begin
                kv = 1'b0;
                stalled++;
            end else begin
                kv = ($urandom_range(0, 99) >= pct);
            end
            bus.key_valid = kv;
            bus.key_word  = kv ? rk[k] : rand128();
            tick();
            if (kv) k++;
        end
        // subkey traffic in DONE must be ignored
        bus.key_valid = 1'($urandom_range(0, 1));
        bus.key_word  = rand128();
        if (b2b) begin
            bus.in_valid = 1'b1;
            bus.in_block = next_pt;
        end
        for (int h = 0; h <= hold; h++) begin
            bus.out_ready = (h == hold);
            chk($sformatf("done_out_valid_%0d", h), 128'(bus.out_valid), 128'd1);
            chk($sformatf("done_out_block_%0d", h), bus.out_block,       stage[NR]);
            chk($sformatf("done_in_ready_%0d", h),  128'(bus.in_ready),  128'd0);
            chk($sformatf("done_key_req_%0d", h),   128'(bus.key_req),   128'd0);
            chk($sformatf("done_busy_%0d", h),      128'(busy),          128'd1);
            last_out = bus.out_block;
            tick();
        end
        bus.out_ready = 1'b0;
        bus.key_valid = 1'b0;
        chk("idle_out_valid", 128'(bus.out_valid), 128'd0);
        chk("idle_in_ready",  128'(bus.in_ready),  128'd1);
        chk("idle_busy",      128'(busy),          128'd0);
    endtask

    initial begin
        logic [127:0] fips_key, fips_pt, fips_ct, p1, p2;
        fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_pt  = 128'h3243f6a8885a308d313198a2e0370734;
        fips_ct  = 128'h3925841d02dc09fbdc118597196a0b32;

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_block = '0;
        bus.key_valid = 1'b0; bus.key_word = '0;
        bus.out_ready = 1'b0;
`ifdef AES_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // FIPS-197 Appendix B, subkeys always valid
        set_key(fips_key);
        last_out = '0;
        run_block(fips_pt, 0, -1, 0, 0, 1'b0, '0, -1, -1);
        chk("fips_ct", last_out, fips_ct);

        // three-cycle subkey stall at index 5
        last_out = '0;
        run_block(fips_pt, 0, 5, 3, 0, 1'b0, '0, -1, -1);
        chk("fips_ct_stall", last_out, fips_ct);

        // sink backpressure in DONE
        run_block(rand128(), 0, -1, 0, 4, 1'b0, '0, -1, -1);

        // back-to-back with in_valid held high
        p1 = rand128();
        p2 = rand128();
        run_block(p1, 0, -1, 0, 1, 1'b1, p2, -1, -1);
        run_block(p2, 0, -1, 0, 0, 1'b0, '0, -1, -1);

        // reset mid-operation, then a clean block
        run_block(rand128(), 0, -1, 0, 0, 1'b0, '0, 7, -1);
        run_block(fips_pt, 0, -1, 0, 0, 1'b0, '0, -1, -1);
        chk("post_reset_ct", last_out, fips_ct);

`ifdef AES_ABORT_EN
        run_block(rand128(), 0, -1, 0, 0, 1'b0, '0, -1, 3);
        run_block(rand128(), 0, -1, 0, 0, 1'b0, '0, -1, 99);
        run_block(fips_pt, 0, -1, 0, 0, 1'b0, '0, -1, -1);
        chk("post_abort_ct", last_out, fips_ct);
`endif

        // random keys, plaintexts, subkey stalls and sink backpressure
        for (int n = 0; n < 12; n++) begin
            set_key(rand128());
            run_block(rand128(), 30, -1, 0, int'($urandom_range(0, 3)), 1'b0, '0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
